// File: rtl/blft_wb.sv
// Write buffer between the bilateral-filter core and the result memory.
// Optional frame checksum is built only when BLFT_WB_CHECKSUM_EN is defined.
module blft_wb #(
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_PIX  = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_addr,
  input  logic [7:0]  in_data,
  input  logic        in_finish,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_gnt,
  output logic        done,
  output logic        overflow,
  output logic [16:0] pix_cnt,
  output logic [15:0] checksum
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [16:0]   CNT_MAX  = 17'h1FFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Unsupported configurations show up as this block in the elaborated hierarchy.
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || FRAME_PIX < 1) begin : g_unsupported_config
  end

  logic [23:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  state_t        r_state;

  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_new_frame;
  logic [AW-1:0] w_rptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [23:0]   w_head_nxt;

  // Accept/pop decisions and the head entry the output register loads next.
  always_comb begin
    w_pop       = mem_req && mem_gnt;
    w_push      = in_valid && ((r_count != FULL_CNT) || w_pop);
    w_drop      = in_valid && !w_push;
    w_new_frame = (r_state == S_DONE) && in_valid;
    w_rptr_nxt  = w_pop ? (r_rptr + AW'(1)) : r_rptr;
    w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    // A push that lands in the slot becoming head is not in r_mem yet.
    if (w_push && (w_rptr_nxt == r_wptr)) begin
      w_head_nxt = {in_addr, in_data};
    end else begin
      w_head_nxt = r_mem[w_rptr_nxt];
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wptr] <= {in_addr, in_data};
    end
  end

  // Pointers, occupancy and the registered memory-write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= 16'd0;
      mem_wdata <= 8'd0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      mem_req <= (w_count_nxt != '0);
      if (w_count_nxt != '0) begin
        {mem_addr, mem_wdata} <= w_head_nxt;
      end
    end
  end

  // Frame FSM with registered done flag, plus pixel count and overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      done     <= 1'b0;
      overflow <= 1'b0;
      pix_cnt  <= 17'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_finish) begin
            r_state <= S_DRAIN;
          end else if (in_valid) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (in_finish) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((r_count == '0) && !mem_req && !in_valid) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end
        end
        S_DONE: begin
          if (in_valid) begin
            r_state <= in_finish ? S_DRAIN : S_RUN;
            done    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          done    <= 1'b0;
        end
      endcase

      if (w_new_frame) begin
        pix_cnt  <= 17'd1;
        overflow <= 1'b0;
      end else begin
        if (w_push && (pix_cnt != CNT_MAX)) begin
          pix_cnt <= pix_cnt + 17'd1;
        end
        if (w_drop) begin
          overflow <= 1'b1;
        end
      end
    end
  end

`ifdef BLFT_WB_CHECKSUM_EN
  // Running 16-bit sum of accepted pixel values, restarted with each frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= 16'd0;
    end else if (w_new_frame) begin
      checksum <= {8'd0, in_data};
    end else if (w_push) begin
      checksum <= checksum + {8'd0, in_data};
    end
  end
`else
  assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_blft_wb.sv
// Scoreboard bench for blft_wb: an occupancy/queue reference model predicts
// every cycle, a negedge monitor compares and retires granted writes.
module tb_blft_wb;
  localparam int DEPTH = 8;
`ifdef BLFT_WB_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_addr = 16'd0;
  logic [7:0]  in_data = 8'd0;
  logic        in_finish = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        done;
  logic        overflow;
  logic [16:0] pix_cnt;
  logic [15:0] checksum;

  always #5 clk = ~clk;

  blft_wb #(.FIFO_DEPTH(DEPTH), .FRAME_PIX(65536)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .in_finish(in_finish), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .done(done), .overflow(overflow), .pix_cnt(pix_cnt), .checksum(checksum)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_writes = 0;
  bit mon_en = 1'b0;

  // reference model: outstanding writes, frame statistics, frame phase
  logic [23:0] exp_q[$];
  int          m_occ = 0;
  int          m_state = 0;  // 0 idle, 1 run, 2 drain, 3 done
  int          m_cnt = 0;
  logic [15:0] m_sum = 16'd0;
  bit          m_ovf = 1'b0;
  // values expected to be visible on the DUT outputs this cycle
  bit          e_req = 1'b0;
  bit          e_done = 1'b0;
  bit          e_ovf = 1'b0;
  int          e_cnt = 0;
  logic [15:0] e_sum = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("done", 32'(done), 32'(e_done));
      chk("overflow", 32'(overflow), 32'(e_ovf));
      chk("pix_cnt", 32'(pix_cnt), 32'(e_cnt));
      chk("checksum", 32'(checksum), 32'(e_sum));
      if (mem_req) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h with nothing queued", mem_addr, mem_wdata);
        end else begin
          chk("write_head", 32'({mem_addr, mem_wdata}), 32'(exp_q[0]));
          if (mem_gnt && !rst) begin
            void'(exp_q.pop_front());
            n_writes++;
          end
        end
      end
    end
  end

  task automatic publish();
    e_req  = (m_occ > 0);
    e_done = (m_state == 3);
    e_ovf  = m_ovf;
    e_cnt  = m_cnt;
    e_sum  = CS_EN ? m_sum : 16'd0;
  endtask

  task automatic step(input logic v, input logic [15:0] a, input logic [7:0] d,
                      input logic f, input logic g);
    bit pop;
    bit acc;
    in_valid = v; in_addr = a; in_data = d; in_finish = f; mem_gnt = g;
    pop = e_req && g;
    acc = v && ((m_occ < DEPTH) || pop);
    if (m_state == 3 && v) begin
      m_cnt = 0; m_sum = 16'd0; m_ovf = 1'b0;
    end
    if (acc) begin
      exp_q.push_back({a, d});
      if (m_cnt < 131071) m_cnt++;
      m_sum = m_sum + {8'd0, d};
    end else if (v) begin
      m_ovf = 1'b1;
    end
    case (m_state)
      0: if (f) m_state = 2; else if (v) m_state = 1;
      1: if (f) m_state = 2;
      2: if (m_occ == 0 && !e_req && !v) m_state = 3;
      default: if (v) m_state = f ? 2 : 1;
    endcase
    m_occ = m_occ + int'(acc) - int'(pop);
    @(posedge clk);
    publish();
    #1;
  endtask

  task automatic do_reset(input int cyc, input logic g);
    rst = 1'b1;
    mem_gnt = g;
    for (int i = 0; i < cyc; i++) begin
      in_valid = 1'($urandom); in_finish = 1'($urandom);
      in_addr = 16'($urandom); in_data = 8'($urandom);
      @(posedge clk);
      exp_q.delete();
      m_occ = 0; m_state = 0; m_cnt = 0; m_sum = 16'd0; m_ovf = 1'b0;
      publish();
      #1;
    end
    rst = 1'b0; in_valid = 1'b0; in_finish = 1'b0; mem_gnt = 1'b0;
  endtask

  task automatic idle(input int n, input logic g);
    for (int i = 0; i < n; i++) step(1'b0, 16'd0, 8'd0, 1'b0, g);
  endtask

  initial begin
    int w0;
    @(posedge clk); #1;
    do_reset(2, 1'b0);
    mon_en = 1'b1;
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // four pixels, continuous grant, then finish
    w0 = n_writes;
    for (int i = 0; i < 4; i++) step(1'b1, 16'(i), 8'(10 * (i + 1)), 1'b0, 1'b1);
    step(1'b0, 16'd0, 8'd0, 1'b1, 1'b1);
    idle(6, 1'b1);
    chk("t4_writes", 32'(n_writes - w0), 32'd4);
    chk("t4_cnt", 32'(pix_cnt), 32'd4);
    chk("t4_sum", 32'(checksum), CS_EN ? 32'd100 : 32'd0);
    chk("t4_done", 32'(done), 32'd1);

    // ten pixels into a stalled eight-entry buffer
    w0 = n_writes;
    for (int i = 0; i < 10; i++) step(1'b1, 16'(16'h100 + i), 8'(i + 1), 1'b0, 1'b0);
    chk("ovf_cnt", 32'(pix_cnt), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    step(1'b0, 16'd0, 8'd0, 1'b1, 1'b0);
    idle(12, 1'b1);
    chk("ovf_writes", 32'(n_writes - w0), 32'd8);
    chk("ovf_done", 32'(done), 32'd1);

    // new frame from DONE clears statistics
    step(1'b1, 16'd0, 8'd7, 1'b0, 1'b0);
    chk("nf_done", 32'(done), 32'd0);
    chk("nf_ovf", 32'(overflow), 32'd0);
    chk("nf_cnt", 32'(pix_cnt), 32'd1);
    chk("nf_sum", 32'(checksum), CS_EN ? 32'd7 : 32'd0);
    step(1'b0, 16'd0, 8'd0, 1'b1, 1'b1);
    idle(4, 1'b1);

    // held write under five cycles of no grant
    w0 = n_writes;
    step(1'b1, 16'h0010, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_req", 32'(mem_req), 32'd1);
      chk("hold_addr_data", 32'({mem_addr, mem_wdata}), 32'h001055);
      step(1'b0, 16'd0, 8'd0, 1'b0, 1'b0);
    end
    step(1'b0, 16'd0, 8'd0, 1'b1, 1'b1);
    idle(4, 1'b1);
    chk("hold_writes", 32'(n_writes - w0), 32'd1);

    // pixel and finish in the same cycle
    w0 = n_writes;
    step(1'b1, 16'h0020, 8'h01, 1'b0, 1'b1);
    step(1'b1, 16'h0021, 8'hFF, 1'b1, 1'b1);
    idle(5, 1'b1);
    chk("vf_writes", 32'(n_writes - w0), 32'd2);
    chk("vf_cnt", 32'(pix_cnt), 32'd2);
    chk("vf_done", 32'(done), 32'd1);

    // reset with three queued entries and a pending request
    for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h300 + i), 8'(i), 1'b0, 1'b0);
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    do_reset(1, 1'b1);
    chk("post_rst_req", 32'(mem_req), 32'd0);
    chk("post_rst_cnt", 32'(pix_cnt), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);
    w0 = n_writes;
    idle(5, 1'b1);
    chk("post_rst_writes", 32'(n_writes - w0), 32'd0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset(1, 1'($urandom));
      end else begin
        step(1'($urandom_range(0, 99) < 55), 16'($urandom), 8'($urandom),
             1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 50));
      end
    end
    step(1'b0, 16'd0, 8'd0, 1'b1, 1'b1);
    idle(DEPTH + 4, 1'b1);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_done", 32'(done), 32'd1);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
